// File: rtl/boss_hp_ctrl.sv
// boss_hp_ctrl: boss hit points, encounter sequencing, round-robin hit arbitration and fire scheduling
module boss_hp_ctrl #(
   parameter int HP_MAX      = 450,
   parameter int N_SRC       = 4,
   parameter int DMG         = 10,
   parameter int PHASE2_HP   = 300,
   parameter int PHASE3_HP   = 150,
   parameter int INVULN_CYC  = 8,
   parameter int FIRE_PERIOD = 64
) (
   input  logic             clk22,
   input  logic             rst,
   input  logic             gamestart,
   input  logic             enm,
   input  logic [N_SRC-1:0] hit_req,
   output logic [N_SRC-1:0] hit_ack,
   output logic [9:0]       bosshp,
   output logic [1:0]       boss_phase,
   output logic             boss_active,
   output logic             boss_fire,
   output logic             boss_dead,
   output logic             win
);
   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int IW = (INVULN_CYC > 1) ? $clog2(INVULN_CYC) : 1;
   localparam int FW = $clog2(FIRE_PERIOD);
   localparam logic [9:0] HP_INIT = 10'(HP_MAX);
   localparam logic [9:0] HP_DMG = 10'(DMG);
   localparam logic [9:0] HP_P2 = 10'(PHASE2_HP);
   localparam logic [9:0] HP_P3 = 10'(PHASE3_HP);
   localparam logic [IW-1:0] INV_LAST = IW'(INVULN_CYC - 1);
   localparam logic [FW-1:0] F1_LAST = FW'(FIRE_PERIOD - 1);
   localparam logic [FW-1:0] F2_LAST = FW'(FIRE_PERIOD / 2 - 1);
   localparam logic [FW-1:0] F3_LAST = FW'(FIRE_PERIOD / 4 - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(N_SRC - 1);

   typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_INVULN, S_DEAD} state_t;

   state_t        state;
   logic [PW-1:0] ptr, gnt_idx, idx;
   logic          gnt_vld;
   logic [IW-1:0] icnt;
   logic [FW-1:0] fcnt, fire_last;
   logic [9:0]    hp_dmg;
   logic [1:0]    phase_now;
   logic          live, hit, dmg_hit, phase_chg;

   function automatic logic [1:0] phase_of(input logic [9:0] hp);
      return (hp > HP_P2) ? 2'd1 : (hp > HP_P3) ? 2'd2 : (hp != 10'd0) ? 2'd3 : 2'd0;
   endfunction

   // round-robin search from the pointer upward with wrap; the lowest offset wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % N_SRC);
         if (hit_req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   // gamestart suppresses acks and shots in the same cycle it restarts the encounter
   assign boss_active = (state == S_ACTIVE) || (state == S_INVULN);
   assign live        = boss_active && !gamestart;
   assign hit         = live && gnt_vld;
   assign dmg_hit     = hit && (state == S_ACTIVE);
   assign hit_ack     = hit ? (N_SRC'(1) << gnt_idx) : '0;
   assign hp_dmg      = (bosshp <= HP_DMG) ? 10'd0 : bosshp - HP_DMG;
   assign phase_now   = phase_of(bosshp);
   assign phase_chg   = phase_of(hp_dmg) != phase_now;
   assign boss_phase  = boss_active ? phase_now : 2'd0;
   assign fire_last   = (phase_now == 2'd1) ? F1_LAST : (phase_now == 2'd2) ? F2_LAST : F3_LAST;
   assign boss_fire   = live && (fcnt == fire_last);
   assign boss_dead   = state == S_DEAD;

   // encounter state, hit points, arbitration pointer, invulnerability and fire counters
   always_ff @(posedge clk22 or negedge rst) begin
      if (!rst) begin
         state  <= S_WAIT;
         bosshp <= HP_INIT;
         ptr    <= '0;
         icnt   <= '0;
         fcnt   <= '0;
         win    <= 1'b0;
      end else if (gamestart) begin
         state  <= S_WAIT;
         bosshp <= HP_INIT;
         ptr    <= '0;
         icnt   <= '0;
         fcnt   <= '0;
         win    <= 1'b0;
      end else begin
         win <= 1'b0;
         if (hit) ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
         case (state)
            S_WAIT: begin
               if (!enm) begin
                  state <= S_ACTIVE;
                  fcnt  <= '0;
               end
            end
            S_ACTIVE, S_INVULN: begin
               fcnt <= (boss_fire || (dmg_hit && phase_chg)) ? '0 : fcnt + 1'b1;
               if (dmg_hit) begin
                  bosshp <= hp_dmg;
                  state  <= (hp_dmg == 10'd0) ? S_DEAD : S_INVULN;
                  win    <= hp_dmg == 10'd0;
                  icnt   <= '0;
               end else if (state == S_INVULN) begin
                  state <= (icnt == INV_LAST) ? S_ACTIVE : S_INVULN;
                  icnt  <= icnt + 1'b1;
               end
            end
            default: begin
               bosshp <= 10'd0;
               fcnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_boss_hp_ctrl.sv
// tb_boss_hp_ctrl: scoreboard bench for the boss HP controller
module tb_boss_hp_ctrl;
   logic       clk22 = 1'b0;
   logic       rst, gamestart, enm, gamestart2, enm2;
   logic [3:0] hit_req, hit_req2, hit_ack, hit_ack2;
   logic [9:0] bosshp, bosshp2;
   logic [1:0] boss_phase, boss_phase2;
   logic       boss_active, boss_fire, boss_dead, win;
   logic       boss_active2, boss_fire2, boss_dead2, win2;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         n0, g, t;

   typedef struct {int c; logic [3:0] v;} ev_t;
   ev_t ack_q[$];
   int  fire_q[$];
   int  win_q[$];

   boss_hp_ctrl #(.HP_MAX(450), .N_SRC(4), .DMG(10), .PHASE2_HP(300), .PHASE3_HP(150),
                  .INVULN_CYC(8), .FIRE_PERIOD(64)) dut (
      .clk22(clk22), .rst(rst), .gamestart(gamestart), .enm(enm), .hit_req(hit_req),
      .hit_ack(hit_ack), .bosshp(bosshp), .boss_phase(boss_phase), .boss_active(boss_active),
      .boss_fire(boss_fire), .boss_dead(boss_dead), .win(win));

   boss_hp_ctrl #(.HP_MAX(25), .N_SRC(4), .DMG(10), .PHASE2_HP(300), .PHASE3_HP(150),
                  .INVULN_CYC(8), .FIRE_PERIOD(64)) dut2 (
      .clk22(clk22), .rst(rst), .gamestart(gamestart2), .enm(enm2), .hit_req(hit_req2),
      .hit_ack(hit_ack2), .bosshp(bosshp2), .boss_phase(boss_phase2), .boss_active(boss_active2),
      .boss_fire(boss_fire2), .boss_dead(boss_dead2), .win(win2));

   always #5 clk22 = ~clk22;
   always @(posedge clk22) cyc <= cyc + 1;

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic go(input int at);
      while (cyc < at) @(negedge clk22);
   endtask

   task automatic push_ack(input int c, input logic [3:0] v);
      ev_t e;
      e.c = c;
      e.v = v;
      ack_q.push_back(e);
   endtask

   // single-source request for one cycle; a lone requester must be granted its own bit
   task automatic hit(input int at, input logic [3:0] req);
      go(at);
      hit_req = req;
      push_ack(at, req);
      go(at + 1);
      hit_req = '0;
   endtask

   // monitor: samples mid-cycle and retires scoreboard entries whose cycle has come
   initial begin
      ev_t e;
      forever begin
         @(negedge clk22);
         #2;
         if (rst) begin
            if (ack_q.size() != 0 && ack_q[0].c == cyc) begin
               e = ack_q.pop_front();
               cmp("hit_ack", int'(hit_ack), int'(e.v));
            end else if (hit_ack != 4'd0) cmp("hit_ack unexpected", int'(hit_ack), 0);
            if (fire_q.size() != 0 && fire_q[0] == cyc) begin
               void'(fire_q.pop_front());
               cmp("boss_fire", int'(boss_fire), 1);
            end else if (boss_fire) cmp("boss_fire unexpected", 1, 0);
            if (win_q.size() != 0 && win_q[0] == cyc) begin
               void'(win_q.pop_front());
               cmp("win", int'(win), 1);
            end else if (win) cmp("win unexpected", 1, 0);
         end
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; gamestart = 1'b0; enm = 1'b1; hit_req = '0;
      gamestart2 = 1'b0; enm2 = 1'b1; hit_req2 = '0;
      repeat (3) @(negedge clk22);
      cmp("rst bosshp", int'(bosshp), 450);
      cmp("rst active", int'(boss_active), 0);
      cmp("rst phase", int'(boss_phase), 0);
      cmp("rst dead", int'(boss_dead), 0);
      cmp("rst ack", int'(hit_ack), 0);
      rst = 1'b1;
      // enemies still alive: boss must stay waiting
      repeat (20) @(negedge clk22);
      cmp("wait active", int'(boss_active), 0);
      cmp("wait bosshp", int'(bosshp), 450);
      n0 = cyc;
      enm = 1'b0;
      fire_q.push_back(n0 + 64);
      fire_q.push_back(n0 + 128);
      for (int k = 0; k < 4; k++) fire_q.push_back(n0 + 163 + 32 * k);
      for (int k = 0; k < 8; k++) fire_q.push_back(n0 + 282 + 16 * k);
      win_q.push_back(n0 + 402);
      go(n0 + 1);
      cmp("enter active", int'(boss_active), 1);
      cmp("phase1", int'(boss_phase), 1);
      // damage, invulnerable ack, damage again after the window
      hit(n0 + 2, 4'b0001);
      cmp("hp after hit", int'(bosshp), 440);
      hit(n0 + 5, 4'b0001);
      cmp("hp invuln hit", int'(bosshp), 440);
      hit(n0 + 11, 4'b1000);
      cmp("hp after window", int'(bosshp), 430);
      // round robin with all sources requesting, pointer at 0
      go(n0 + 22);
      hit_req = 4'b1111;
      push_ack(n0 + 22, 4'b0001);
      push_ack(n0 + 23, 4'b0010);
      push_ack(n0 + 24, 4'b0100);
      push_ack(n0 + 25, 4'b1000);
      push_ack(n0 + 26, 4'b0001);
      go(n0 + 27);
      hit_req = '0;
      cmp("hp rr", int'(bosshp), 420);
      // phase 1 -> 2
      for (int k = 0; k < 11; k++) hit(n0 + 32 + 9 * k, 4'b0001);
      go(n0 + 131);
      cmp("hp 310", int'(bosshp), 310);
      cmp("phase1 at 310", int'(boss_phase), 1);
      hit(n0 + 131, 4'b0001);
      cmp("hp 300", int'(bosshp), 300);
      cmp("phase2", int'(boss_phase), 2);
      // phase 2 -> 3
      for (int k = 0; k < 15; k++) hit(n0 + 140 + 9 * k, 4'b0001);
      cmp("hp 150", int'(bosshp), 150);
      cmp("phase3", int'(boss_phase), 3);
      // down to the final hit
      for (int k = 0; k < 14; k++) hit(n0 + 275 + 9 * k, 4'b0001);
      cmp("hp 10", int'(bosshp), 10);
      hit(n0 + 401, 4'b0001);
      cmp("dead hp", int'(bosshp), 0);
      cmp("dead flag", int'(boss_dead), 1);
      cmp("dead active", int'(boss_active), 0);
      cmp("dead phase", int'(boss_phase), 0);
      hit_req = 4'b1111;
      #1 cmp("dead ack", int'(hit_ack), 0);
      go(n0 + 406);
      hit_req = '0;
      cmp("dead holds", int'(boss_dead), 1);
      // gamestart restarts, then again mid-invulnerability with a pending request
      g = n0 + 410;
      go(g);
      gamestart = 1'b1;
      go(g + 1);
      gamestart = 1'b0;
      cmp("gs bosshp", int'(bosshp), 450);
      cmp("gs dead", int'(boss_dead), 0);
      cmp("gs active", int'(boss_active), 0);
      go(g + 2);
      cmp("gs reactive", int'(boss_active), 1);
      hit(g + 3, 4'b0001);
      cmp("gs hp 440", int'(bosshp), 440);
      go(g + 5);
      gamestart = 1'b1;
      enm = 1'b1;
      hit_req = 4'b0010;
      #1 cmp("gs ack blocked", int'(hit_ack), 0);
      go(g + 6);
      gamestart = 1'b0;
      cmp("gs2 bosshp", int'(bosshp), 450);
      cmp("gs2 active", int'(boss_active), 0);
      #1 cmp("gs2 ack wait", int'(hit_ack), 0);
      go(g + 7);
      hit_req = '0;
      enm = 1'b0;
      go(g + 8);
      cmp("gs2 reactive", int'(boss_active), 1);
      hit(g + 9, 4'b0001);
      cmp("pre-rst hp", int'(bosshp), 440);
      // asynchronous reset between clock edges
      enm = 1'b1;
      #3 rst = 1'b0;
      #1;
      cmp("async bosshp", int'(bosshp), 450);
      cmp("async active", int'(boss_active), 0);
      cmp("async phase", int'(boss_phase), 0);
      @(negedge clk22);
      rst = 1'b1;
      // saturating lethal hit: 25 -> 15 -> 5 -> 0
      t = cyc + 2;
      go(t);
      enm2 = 1'b0;
      go(t + 2);
      hit_req2 = 4'b0001;
      #1 cmp("u2 ack1", int'(hit_ack2), 1);
      go(t + 3);
      hit_req2 = '0;
      cmp("u2 hp15", int'(bosshp2), 15);
      go(t + 11);
      hit_req2 = 4'b0001;
      #1 cmp("u2 ack2", int'(hit_ack2), 1);
      go(t + 12);
      hit_req2 = '0;
      cmp("u2 hp5", int'(bosshp2), 5);
      cmp("u2 phase3", int'(boss_phase2), 3);
      go(t + 20);
      hit_req2 = 4'b0001;
      #1 cmp("u2 ack3", int'(hit_ack2), 1);
      go(t + 21);
      hit_req2 = '0;
      cmp("u2 hp0", int'(bosshp2), 0);
      cmp("u2 dead", int'(boss_dead2), 1);
      cmp("u2 win", int'(win2), 1);
      cmp("u2 fire dead", int'(boss_fire2), 0);
      go(t + 22);
      hit_req2 = 4'b1111;
      #1;
      cmp("u2 win once", int'(win2), 0);
      cmp("u2 ack dead", int'(hit_ack2), 0);
      cmp("u2 fire dead2", int'(boss_fire2), 0);
      cmp("u2 dead holds", int'(boss_dead2), 1);
      go(t + 24);
      hit_req2 = '0;
      cmp("ack_q drained", ack_q.size(), 0);
      cmp("fire_q drained", fire_q.size(), 0);
      cmp("win_q drained", win_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
